// File: rtl/lutram_test_pkg.sv
// Shared encodings for the LUTRAM readback checker and its test harness.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lutram_test_pkg;

  // Checker run state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Harness phase sequence used to drive a check run.
  typedef enum logic [2:0] {
    PH_INITIAL = 3'd0,
    PH_CLEAR   = 3'd1,
    PH_WRITE   = 3'd2,
    PH_READ    = 3'd3,
    PH_FINISH  = 3'd4
  } phase_e;

endpackage

// File: rtl/lutram_shadow_model.sv
// Shadow copy of the LUTRAM under test plus a per-address read-coverage bitmap.
// Latency: write/cover on the clock edge; rd_o is combinational from current contents.
// Backpressure: none, accepts one write and one read every cycle.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   clr_i                  clear memory and coverage (wins over write/read)
//   we_i, waddr_i, wd_i    write port
//   re_i, raddr_i          read port; re_i marks raddr_i as covered
//   rd_o                   shadow contents at raddr_i
//   all_covered_o          every address covered, counting the read presented now
module lutram_shadow_model #(
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              wd_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic              rd_o,
  output logic              all_covered_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_mem;
  logic [DEPTH-1:0] r_cov;
  logic [DEPTH-1:0] w_rd_hit;

  always_comb begin
    w_rd_hit = '0;
    if (re_i) w_rd_hit[raddr_i] = 1'b1;
  end

  assign rd_o = r_mem[raddr_i];
  // Includes the read being accepted this cycle so a verdict formed on the
  // same edge as a final read sees that address as covered.
  assign all_covered_o = &(r_cov | w_rd_hit);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      r_mem <= '0;
      r_cov <= '0;
    end else begin
      if (we_i) r_mem[waddr_i] <= wd_i;
      if (re_i) r_cov[raddr_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/lutram_readback_checker.sv
// Checks LUTRAM spo/dpo read data against a shadow copy; issues pass/fail verdict.
// Latency: mismatch counted one edge after the read; done_o one cycle after finish_i.
// Backpressure: none, one access per cycle is always accepted in RUN.
//
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   start_i, finish_i         begin (or restart) / end a check run
//   valid_i, we_i, addr_i, d_i  access presented to the LUTRAM this cycle
//   spo_i, dpo_i              LUTRAM single-/dual-port read outputs
//   done_o, pass_o            verdict valid / run passed
//   err_cnt_o                 saturating mismatch count
//   first_err_addr_o          address of the first mismatching read
//   busy_o                    run in progress
module lutram_readback_checker
  import lutram_test_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int ERR_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              valid_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              d_i,
  input  logic              spo_i,
  input  logic              dpo_i,
  input  logic              finish_i,
  output logic              done_o,
  output logic              pass_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic              busy_o
);

  state_e r_state;
  state_e w_state_nxt;

  logic              r_done;
  logic              r_pass;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0] r_first_err;

  logic              w_in_run;
  logic              w_wr;
  logic              w_rd;
  logic              w_fin;
  logic              w_sh_bit;
  logic              w_all_cov;
  logic              w_mis;
  logic [ERR_W-1:0]  w_err_nxt;

  // A start pulse in RUN restarts the run, so it masks any access or finish
  // presented on the same cycle.
  assign w_in_run = (r_state == RUN) && !start_i;
  assign w_wr     = w_in_run && valid_i && we_i;
  assign w_rd     = w_in_run && valid_i && !we_i;
  assign w_fin    = w_in_run && finish_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_nxt = RUN;
      RUN:     if (start_i) w_state_nxt = RUN;
               else if (finish_i) w_state_nxt = DONE;
      DONE:    if (start_i) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  lutram_shadow_model #(
    .ADDR_W(ADDR_W)
  ) u_shadow (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (start_i),
    .we_i         (w_wr),
    .waddr_i      (addr_i),
    .wd_i         (d_i),
    .re_i         (w_rd),
    .raddr_i      (addr_i),
    .rd_o         (w_sh_bit),
    .all_covered_o(w_all_cov)
  );

  assign w_mis     = w_rd && ((spo_i != w_sh_bit) || (dpo_i != w_sh_bit));
  assign w_err_nxt = (w_mis && !(&r_err_cnt)) ? r_err_cnt + ERR_W'(1) : r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || start_i) begin
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else if (r_state == RUN) begin
      r_err_cnt <= w_err_nxt;
      // Counter saturates and never returns to zero, so zero means no
      // mismatch has been seen yet in this run.
      if (w_mis && (r_err_cnt == '0)) r_first_err <= addr_i;
      if (w_fin) begin
        r_done <= 1'b1;
        // Next-state count folds in a read coinciding with finish_i.
        r_pass <= (w_err_nxt == '0) && w_all_cov;
      end
    end
  end

  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_first_err;
  assign busy_o           = (r_state == RUN);

endmodule

// File: tb/tb_lutram_readback_checker.sv
module tb_lutram_readback_checker;
  import lutram_test_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, valid, we, d, spo, spo2, dpo, finish;
  logic [5:0] addr;

  logic       done0, pass0, busy0;
  logic [7:0] err0;
  logic [5:0] first0;
  logic       done1, pass1, busy1;
  logic [1:0] err1;
  logic [5:0] first1;

  lutram_readback_checker #(.ADDR_W(6), .ERR_W(8)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_i(valid), .we_i(we),
    .addr_i(addr), .d_i(d), .spo_i(spo), .dpo_i(dpo), .finish_i(finish),
    .done_o(done0), .pass_o(pass0), .err_cnt_o(err0),
    .first_err_addr_o(first0), .busy_o(busy0)
  );

  lutram_readback_checker #(.ADDR_W(6), .ERR_W(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_i(valid), .we_i(we),
    .addr_i(addr), .d_i(d), .spo_i(spo2), .dpo_i(dpo), .finish_i(finish),
    .done_o(done1), .pass_o(pass1), .err_cnt_o(err1),
    .first_err_addr_o(first1), .busy_o(busy1)
  );

  int     total = 0;
  int     bad   = 0;
  bit     chk_en = 1'b0;
  phase_e phase = PH_INITIAL;
  bit     ram [64];

  // Reference model: what a checker run must report, from the rules alone.
  state_e m_state = IDLE;
  bit     m_shadow [64];
  bit     m_cov [64];
  int     m_cnt [2];
  int     m_first [2];
  bit     m_seen [2];
  bit     m_done = 1'b0;
  bit     m_pass [2];
  int     m_max [2] = '{255, 3};

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_shadow[i] = 1'b0;
      m_cov[i]    = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_first[k] = 0; m_seen[k] = 1'b0; m_pass[k] = 1'b0;
    end
    m_done = 1'b0;
  endtask

  always @(posedge clk) begin : mdl
    bit sp;
    bit every;
    if (!rst_n) begin
      m_state = IDLE;
      model_clear();
    end else if (start) begin
      m_state = RUN;
      model_clear();
    end else if (m_state == RUN) begin
      if (valid && we) begin
        m_shadow[addr] = d;
      end else if (valid) begin
        m_cov[addr] = 1'b1;
        for (int k = 0; k < 2; k++) begin
          sp = (k == 0) ? spo : spo2;
          if (sp != m_shadow[addr] || dpo != m_shadow[addr]) begin
            if (!m_seen[k]) begin
              m_seen[k]  = 1'b1;
              m_first[k] = int'(addr);
            end
            if (m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
      if (finish) begin
        m_state = DONE;
        m_done  = 1'b1;
        every   = 1'b1;
        for (int i = 0; i < 64; i++) every = every & m_cov[i];
        for (int k = 0; k < 2; k++) m_pass[k] = (m_cnt[k] == 0) && every;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_done0",  32'(done0),  32'(m_done));
      cmp("m_pass0",  32'(pass0),  32'(m_pass[0]));
      cmp("m_busy0",  32'(busy0),  32'(m_state == RUN));
      cmp("m_err0",   32'(err0),   32'(m_cnt[0]));
      cmp("m_first0", 32'(first0), 32'(m_first[0]));
      cmp("m_done1",  32'(done1),  32'(m_done));
      cmp("m_pass1",  32'(pass1),  32'(m_pass[1]));
      cmp("m_busy1",  32'(busy1),  32'(m_state == RUN));
      cmp("m_err1",   32'(err1),   32'(m_cnt[1]));
      cmp("m_first1", 32'(first1), 32'(m_first[1]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_write(input int a, input bit v);
    valid = 1'b1; we = 1'b1; addr = 6'(a); d = v; ram[a] = v;
    cyc();
    valid = 1'b0; we = 1'b0; d = 1'b0;
  endtask

  // flip: LUTRAM dual-port output returns the wrong bit; inv2: second checker
  // sees an inverted single-port output.
  task automatic do_read(input int a, input bit fin, input bit flip, input bit inv2);
    valid = 1'b1; we = 1'b0; addr = 6'(a);
    spo  = ram[a];
    dpo  = flip ? ~ram[a] : ram[a];
    spo2 = inv2 ? ~ram[a] : ram[a];
    finish = fin;
    cyc();
    valid = 1'b0; finish = 1'b0; spo = 1'b0; dpo = 1'b0; spo2 = 1'b0;
  endtask

  task automatic do_finish();
    phase = PH_FINISH;
    finish = 1'b1; cyc(); finish = 1'b0;
  endtask

  task automatic prep_run();
    do_start();
    phase = PH_CLEAR;
    for (int a = 0; a < 64; a++) do_write(a, 1'b0);
    phase = PH_WRITE;
    for (int a = 0; a < 64; a++) do_write(a, a[0]);
    phase = PH_READ;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; we = 1'b0; addr = '0; d = 1'b0;
    spo = 1'b0; spo2 = 1'b0; dpo = 1'b0; finish = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    cmp("rst_done", 32'(done0), 0);
    cmp("rst_pass", 32'(pass0), 0);
    cmp("rst_busy", 32'(busy0), 0);
    cmp("rst_err", 32'(err0), 0);
    cmp("rst_first", 32'(first0), 0);
    rst_n = 1'b1;
    // Accesses and finish in IDLE are ignored.
    do_read(3, 1'b1, 1'b1, 1'b1);
    cmp("idle_done", 32'(done0), 0);
    cmp("idle_err", 32'(err0), 0);

    // Full correct run.
    prep_run();
    cmp("run_busy", 32'(busy0), 1);
    for (int a = 0; a < 64; a++) do_read(a, 1'b0, 1'b0, 1'b0);
    do_finish();
    cmp("full_done", 32'(done0), 1);
    cmp("full_pass", 32'(pass0), 1);
    cmp("full_err", 32'(err0), 0);
    cmp("full_busy", 32'(busy0), 0);

    // Single dpo mismatch at address 6.
    prep_run();
    cmp("restart_done", 32'(done0), 0);
    for (int a = 0; a < 64; a++) do_read(a, 1'b0, a == 6, 1'b0);
    do_finish();
    cmp("dpo6_done", 32'(done0), 1);
    cmp("dpo6_pass", 32'(pass0), 0);
    cmp("dpo6_err", 32'(err0), 1);
    cmp("dpo6_first", 32'(first0), 6);

    // Incomplete coverage.
    prep_run();
    for (int a = 0; a < 32; a++) do_read(a, 1'b0, 1'b0, 1'b0);
    do_finish();
    cmp("half_done", 32'(done0), 1);
    cmp("half_pass", 32'(pass0), 0);
    cmp("half_err", 32'(err0), 0);

    // Saturation in the 2-bit counter instance.
    prep_run();
    for (int a = 0; a < 64; a++) begin
      do_read(a, 1'b0, 1'b0, 1'b1);
      if (a == 1) cmp("sat_err1_two", 32'(err1), 2);
      if (a == 2 || a == 40) cmp("sat_err1_three", 32'(err1), 3);
    end
    do_finish();
    cmp("sat_err1", 32'(err1), 3);
    cmp("sat_pass1", 32'(pass1), 0);
    cmp("sat_first1", 32'(first1), 0);
    cmp("sat_pass0", 32'(pass0), 1);

    // Finish coinciding with a mismatching read of the top address.
    prep_run();
    for (int a = 0; a < 63; a++) do_read(a, 1'b0, 1'b0, 1'b0);
    cmp("fin63_pre_done", 32'(done0), 0);
    cmp("fin63_pre_err", 32'(err0), 0);
    phase = PH_FINISH;
    do_read(63, 1'b1, 1'b1, 1'b0);
    cmp("fin63_done", 32'(done0), 1);
    cmp("fin63_err", 32'(err0), 1);
    cmp("fin63_pass", 32'(pass0), 0);
    cmp("fin63_first", 32'(first0), 63);

    // Reset in the middle of the read phase, then a fresh correct run.
    prep_run();
    for (int a = 0; a < 20; a++) do_read(a, 1'b0, a == 5, 1'b0);
    cmp("mid_err", 32'(err0), 1);
    cmp("mid_first", 32'(first0), 5);
    rst_n = 1'b0;
    do_read(20, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    cmp("mrst_busy", 32'(busy0), 0);
    cmp("mrst_done", 32'(done0), 0);
    cmp("mrst_pass", 32'(pass0), 0);
    cmp("mrst_err", 32'(err0), 0);
    cmp("mrst_first", 32'(first0), 0);
    do_finish();
    cmp("mrst_fin_ignored", 32'(done0), 0);
    prep_run();
    for (int a = 0; a < 64; a++) do_read(a, 1'b0, 1'b0, 1'b0);
    do_finish();
    cmp("after_rst_done", 32'(done0), 1);
    cmp("after_rst_pass", 32'(pass0), 1);
    cmp("after_rst_err", 32'(err0), 0);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
